// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the Tamagotchi state controller: one-hot state
// encoding and the default stat width.
package tamagotchi_pkg;

    localparam int unsigned StateW       = 5;
    localparam int unsigned StatWDefault = 8;

    // INTRO is the all-zero code; the remaining states are one-hot.
    typedef enum logic [StateW-1:0] {
        StIntro     = 5'd0,
        StIdle      = 5'd1,
        StDormindo  = 5'd2,
        StComendo   = 5'd4,
        StDandoAula = 5'd8,
        StMorto     = 5'd16
    } estado_e;

endpackage

// File: rtl/divisor_tick.sv
// Free-running divider: strobe_o is high for one cycle out of every TICK_DIV,
// in the cycle where the internal count sits at TICK_DIV-1.
module divisor_tick #(
    parameter int unsigned TICK_DIV = 4194304
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic strobe_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Strobe on the last count, then wrap to zero.
    always_comb begin
        strobe_o = (cnt_q == CntMax);
        cnt_d    = strobe_o ? '0 : cnt_q + CntW'(1);
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controlador_estados_param.sv
// Tamagotchi pet-state controller. Evaluates the pet state once per tick from
// latched buttons and the hunger/happiness/sleep stats, with a long-press
// return to INTRO and a registered low-stat alert.
// Optional: define CONTROLADOR_AUTO_SLEEP_EN to send an unattended IDLE pet to
// DORMINDO after IDLE_TIMEOUT quiet evaluations.
module controlador_estados_param
    import tamagotchi_pkg::*;
#(
    parameter int unsigned STAT_W         = StatWDefault,
    parameter int unsigned TICK_DIV       = 4194304,
    parameter int unsigned RESET_HOLD_CYC = 4194304,
    parameter int unsigned LOW_THR        = 32,
    parameter int unsigned IDLE_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              b1,
    input  logic              b2,
    input  logic [STAT_W-1:0] fome,
    input  logic [STAT_W-1:0] felicidade,
    input  logic [STAT_W-1:0] sono,
    output logic [StateW-1:0] estado,
    output logic              alerta,
    output logic              tick
);

    localparam int unsigned HoldW = $clog2(RESET_HOLD_CYC + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD_CYC);

    // Elaboration-time parameter sanity checks.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (RESET_HOLD_CYC < 1) begin : g_bad_hold
        $error("RESET_HOLD_CYC must be >= 1");
    end
    if (IDLE_TIMEOUT < 1) begin : g_bad_idle
        $error("IDLE_TIMEOUT must be >= 1");
    end

    estado_e          estado_q, estado_d;
    logic             b1_lat_q, b1_lat_d, b2_lat_q, b2_lat_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             alerta_q, alerta_d;
    logic             tick_q;
    logic             eval_strobe;
    logic             b1_eff, b2_eff, rst_req, any_zero, any_low, dead;

    divisor_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_divisor_tick (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .strobe_o (eval_strobe)
    );

    // Button latches, long-press counter and stat predicates.
    always_comb begin
        b1_eff   = b1_lat_q | b1;
        b2_eff   = b2_lat_q | b2;
        rst_req  = (hold_q == HoldMax);
        any_zero = (fome == '0) || (felicidade == '0) || (sono == '0);
        any_low  = (32'(fome) < LOW_THR) || (32'(felicidade) < LOW_THR) ||
                   (32'(sono) < LOW_THR);
        dead     = (estado_q == StMorto) || any_zero;
        b1_lat_d = eval_strobe ? 1'b0 : b1_eff;
        b2_lat_d = eval_strobe ? 1'b0 : b2_eff;
        if (b1 && b2) begin
            hold_d = rst_req ? hold_q : hold_q + HoldW'(1);
        end else begin
            hold_d = '0;
        end
        // A granted long-press is consumed at the evaluation.
        if (eval_strobe && rst_req) begin
            hold_d = '0;
        end
        alerta_d = any_low && (estado_q != StMorto);
    end

`ifdef CONTROLADOR_AUTO_SLEEP_EN
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_TIMEOUT - 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             idle_hit;

    // Count quiet evaluations spent in IDLE; any button or leaving IDLE restarts.
    always_comb begin
        idle_d   = (b1 || b2) ? '0 : idle_q;
        idle_hit = 1'b0;
        if (eval_strobe) begin
            if (!rst_req && !dead && (estado_q == StIdle) && !b1_eff && !b2_eff) begin
                if (idle_q == IdleLast) begin
                    idle_hit = 1'b1;
                    idle_d   = '0;
                end else begin
                    idle_d = idle_q + IdleW'(1);
                end
            end else begin
                idle_d = '0;
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Next-state evaluation, only on the tick strobe.
    always_comb begin
        estado_d = estado_q;
        if (eval_strobe) begin
            if (rst_req) begin
                estado_d = StIntro;
            end else if (dead) begin
                estado_d = StMorto;
`ifdef CONTROLADOR_AUTO_SLEEP_EN
            end else if (idle_hit) begin
                estado_d = StDormindo;
`endif
            end else begin
                case (estado_q)
                    StIdle: begin
                        case ({b1_eff, b2_eff})
                            2'b10:   estado_d = StComendo;
                            2'b01:   estado_d = StDormindo;
                            2'b11:   estado_d = StDandoAula;
                            default: estado_d = StIdle;
                        endcase
                    end
                    default: begin
                        if (b1_eff || b2_eff) begin
                            estado_d = StIdle;
                        end
                    end
                endcase
            end
        end
    end

    // State, latch, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= StIntro;
            b1_lat_q <= 1'b0;
            b2_lat_q <= 1'b0;
            hold_q   <= '0;
            alerta_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            b1_lat_q <= b1_lat_d;
            b2_lat_q <= b2_lat_d;
            hold_q   <= hold_d;
            alerta_q <= alerta_d;
            tick_q   <= eval_strobe;
        end
    end

    assign estado = estado_q;
    assign alerta = alerta_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_controlador_estados_param.sv
// Self-checking bench for controlador_estados_param: directed scenarios with
// constant expectations plus a randomized run against a behavioural model.
module tb_controlador_estados_param;

    localparam int TD = 4;
    localparam int HOLD = 8;
    localparam int THR = 16;
    localparam int IT = 3;

    localparam logic [4:0] E_INTRO = 5'd0;
    localparam logic [4:0] E_IDLE  = 5'd1;
    localparam logic [4:0] E_DORM  = 5'd2;
    localparam logic [4:0] E_COM   = 5'd4;
    localparam logic [4:0] E_AULA  = 5'd8;
    localparam logic [4:0] E_MORTO = 5'd16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b1 = 1'b0;
    logic       b2 = 1'b0;
    logic [7:0] fome = 8'd100;
    logic [7:0] felicidade = 8'd100;
    logic [7:0] sono = 8'd100;
    logic [4:0] estado;
    logic       alerta;
    logic       tick;

    int n_checks = 0;
    int n_errors = 0;

    controlador_estados_param #(
        .STAT_W         (8),
        .TICK_DIV       (TD),
        .RESET_HOLD_CYC (HOLD),
        .LOW_THR        (THR),
        .IDLE_TIMEOUT   (IT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .b1         (b1),
        .b2         (b2),
        .fome       (fome),
        .felicidade (felicidade),
        .sono       (sono),
        .estado     (estado),
        .alerta     (alerta),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Behavioural model: cycle count, pressed-since-last-tick flags,
    // run length of the two-button hold, quiet-evaluation count.
    int         m_cyc, m_run, m_idle;
    bit         m_p1, m_p2, ev, p1, p2, req;
    logic [4:0] m_estado;
    logic       m_alerta, m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_run = 0; m_idle = 0; m_p1 = 0; m_p2 = 0;
            m_estado = E_INTRO; m_alerta = 0; m_tick = 0;
        end else begin
            ev  = (m_cyc % TD) == TD - 1;
            p1  = m_p1 || b1;
            p2  = m_p2 || b2;
            req = m_run >= HOLD;
            m_alerta = (fome < THR || felicidade < THR || sono < THR) && m_estado != E_MORTO;
            m_tick = ev;
            if (b1 || b2) m_idle = 0;
            if (ev) begin
                if (req) begin
                    m_estado = E_INTRO; m_idle = 0;
                end else if (m_estado == E_MORTO || fome == 0 || felicidade == 0 || sono == 0) begin
                    m_estado = E_MORTO; m_idle = 0;
                end else if (m_estado == E_IDLE && !p1 && !p2) begin
`ifdef CONTROLADOR_AUTO_SLEEP_EN
                    m_idle++;
                    if (m_idle == IT) begin
                        m_estado = E_DORM; m_idle = 0;
                    end
`endif
                end else if (m_estado == E_IDLE) begin
                    m_estado = (p1 && p2) ? E_AULA : (p1 ? E_COM : E_DORM);
                    m_idle = 0;
                end else begin
                    if (p1 || p2) m_estado = E_IDLE;
                    m_idle = 0;
                end
                m_p1 = 0; m_p2 = 0;
            end else begin
                m_p1 = p1; m_p2 = p2;
            end
            m_run = (b1 && b2) ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
            if (ev && req) m_run = 0;
            m_cyc++;
        end
    end

    // Drive helpers (no checking inside).
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic goto_count(input int c);
        repeat (TD) if ((m_cyc % TD) != c) step();
    endtask

    task automatic through_eval();
        goto_count(TD - 1);
        step();
    endtask

    task automatic pulse(input bit p_b1, input bit p_b2);
        b1 = p_b1; b2 = p_b2;
        step();
        b1 = 0; b2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; b1 = 0; b2 = 0;
        fome = 100; felicidade = 100; sono = 100;
        step(); step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        int ticks;
        rst_n = 0; b1 = 1;
        step();
        n_checks += 3;
        if (estado !== E_INTRO) begin n_errors++; $display("FAIL reset_estado got=%0d want=%0d", estado, E_INTRO); end
        if (alerta !== 1'b0) begin n_errors++; $display("FAIL reset_alerta got=%0b want=0", alerta); end
        if (tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got=%0b want=0", tick); end
        b1 = 0;
        rst_n = 1;
        ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            ticks += int'(tick);
            n_checks += 2;
            if (tick !== ((k % TD) == 0)) begin n_errors++; $display("FAIL tick_period step=%0d got=%0b want=%0b", k, tick, (k % TD) == 0); end
            if (estado !== E_INTRO) begin n_errors++; $display("FAIL intro_hold step=%0d got=%0d want=%0d", k, estado, E_INTRO); end
        end
        n_checks++;
        if (ticks != 3) begin n_errors++; $display("FAIL tick_count got=%0d want=3", ticks); end
        goto_count(1);
        pulse(0, 1);
        n_checks++;
        if (estado !== E_INTRO) begin n_errors++; $display("FAIL no_early_change got=%0d want=%0d", estado, E_INTRO); end
        step();
        n_checks++;
        if (estado !== E_INTRO) begin n_errors++; $display("FAIL no_change_in_eval got=%0d want=%0d", estado, E_INTRO); end
        step();
        n_checks += 2;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL intro_to_idle got=%0d want=%0d", estado, E_IDLE); end
        if (tick !== 1'b1) begin n_errors++; $display("FAIL tick_after_eval got=%0b want=1", tick); end
    endtask

    task automatic test_idle_cmds();
        goto_count(1); pulse(1, 0); through_eval();
        n_checks++;
        if (estado !== E_COM) begin n_errors++; $display("FAIL idle_b1 got=%0d want=%0d", estado, E_COM); end
        goto_count(1); pulse(1, 0); through_eval();
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL comendo_b1 got=%0d want=%0d", estado, E_IDLE); end
        goto_count(0); pulse(1, 0); pulse(0, 1); through_eval();
        n_checks++;
        if (estado !== E_AULA) begin n_errors++; $display("FAIL idle_both got=%0d want=%0d", estado, E_AULA); end
        goto_count(TD - 1); pulse(0, 1);
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL press_in_eval got=%0d want=%0d", estado, E_IDLE); end
        goto_count(1); pulse(0, 1); through_eval();
        n_checks++;
        if (estado !== E_DORM) begin n_errors++; $display("FAIL idle_b2 got=%0d want=%0d", estado, E_DORM); end
    endtask

    task automatic test_death();
        sono = 0;
        step();
        n_checks++;
        if (alerta !== 1'b1) begin n_errors++; $display("FAIL alert_before_death got=%0b want=1", alerta); end
        through_eval();
        n_checks++;
        if (estado !== E_MORTO) begin n_errors++; $display("FAIL sono_zero got=%0d want=%0d", estado, E_MORTO); end
        step();
        n_checks++;
        if (alerta !== 1'b0) begin n_errors++; $display("FAIL alert_when_dead got=%0b want=0", alerta); end
        sono = 100;
        for (int k = 0; k < 3; k++) begin
            goto_count(1); pulse(1, 0); through_eval();
            n_checks++;
            if (estado !== E_MORTO) begin n_errors++; $display("FAIL morto_sticky k=%0d got=%0d want=%0d", k, estado, E_MORTO); end
        end
    endtask

    task automatic test_hold();
        goto_count(0);
        b1 = 1; b2 = 1;
        repeat (HOLD - 1) step();
        b1 = 0; b2 = 0;
        through_eval(); through_eval();
        n_checks++;
        if (estado !== E_MORTO) begin n_errors++; $display("FAIL short_hold got=%0d want=%0d", estado, E_MORTO); end
        goto_count(2);
        b1 = 1; b2 = 1;
        repeat (HOLD) step();
        n_checks++;
        if (estado !== E_MORTO) begin n_errors++; $display("FAIL hold_8_no_eval got=%0d want=%0d", estado, E_MORTO); end
        step();
        n_checks++;
        if (estado !== E_MORTO) begin n_errors++; $display("FAIL hold_9 got=%0d want=%0d", estado, E_MORTO); end
        step();
        n_checks++;
        if (estado !== E_INTRO) begin n_errors++; $display("FAIL hold_return got=%0d want=%0d", estado, E_INTRO); end
        b1 = 0; b2 = 0;
    endtask

    task automatic test_alert();
        goto_count(1); pulse(1, 0); through_eval();
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL alert_setup got=%0d want=%0d", estado, E_IDLE); end
        fome = 15; step();
        n_checks++;
        if (alerta !== 1'b1) begin n_errors++; $display("FAIL alert_15 got=%0b want=1", alerta); end
        fome = 16; step();
        n_checks++;
        if (alerta !== 1'b0) begin n_errors++; $display("FAIL alert_16 got=%0b want=0", alerta); end
        fome = 0; step();
        n_checks++;
        if (alerta !== 1'b1) begin n_errors++; $display("FAIL alert_0_alive got=%0b want=1", alerta); end
        through_eval(); step();
        n_checks += 2;
        if (estado !== E_MORTO) begin n_errors++; $display("FAIL fome_zero got=%0d want=%0d", estado, E_MORTO); end
        if (alerta !== 1'b0) begin n_errors++; $display("FAIL alert_0_dead got=%0b want=0", alerta); end
    endtask

    task automatic test_auto_sleep();
        do_reset();
        goto_count(1); pulse(0, 1); through_eval();
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL sleep_setup got=%0d want=%0d", estado, E_IDLE); end
`ifdef CONTROLADOR_AUTO_SLEEP_EN
        through_eval(); through_eval();
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL idle_2_evals got=%0d want=%0d", estado, E_IDLE); end
        through_eval();
        n_checks++;
        if (estado !== E_DORM) begin n_errors++; $display("FAIL auto_sleep got=%0d want=%0d", estado, E_DORM); end
        goto_count(1); pulse(1, 0); through_eval();
        through_eval();
        goto_count(1); pulse(0, 1); through_eval();
        n_checks++;
        if (estado !== E_DORM) begin n_errors++; $display("FAIL b2_second_eval got=%0d want=%0d", estado, E_DORM); end
        goto_count(1); pulse(1, 0); through_eval();
        through_eval(); through_eval();
        n_checks++;
        if (estado !== E_IDLE) begin n_errors++; $display("FAIL idle_count_cleared got=%0d want=%0d", estado, E_IDLE); end
        through_eval();
        n_checks++;
        if (estado !== E_DORM) begin n_errors++; $display("FAIL auto_sleep_again got=%0d want=%0d", estado, E_DORM); end
`else
        for (int k = 0; k < 10; k++) begin
            through_eval();
            n_checks++;
            if (estado !== E_IDLE) begin n_errors++; $display("FAIL idle_persist k=%0d got=%0d want=%0d", k, estado, E_IDLE); end
        end
`endif
    endtask

    task automatic test_random();
        int burst;
        do_reset();
        burst = 0;
        for (int k = 0; k < 800; k++) begin
            if (burst > 0) begin
                b1 = 1; b2 = 1; burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                burst = $urandom_range(5, 12);
                b1 = 1; b2 = 1;
            end else begin
                b1 = ($urandom_range(0, 7) == 0);
                b2 = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 15) == 0) begin
                logic [7:0] v;
                v = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(100, 255));
                case ($urandom_range(0, 2))
                    0: fome = v;
                    1: felicidade = v;
                    default: sono = v;
                endcase
            end
            step();
            n_checks += 3;
            if (estado !== m_estado) begin n_errors++; $display("FAIL rand_estado cyc=%0d got=%0d want=%0d", k, estado, m_estado); end
            if (alerta !== m_alerta) begin n_errors++; $display("FAIL rand_alerta cyc=%0d got=%0b want=%0b", k, alerta, m_alerta); end
            if (tick !== m_tick) begin n_errors++; $display("FAIL rand_tick cyc=%0d got=%0b want=%0b", k, tick, m_tick); end
        end
        b1 = 0; b2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        test_reset();
        test_idle_cmds();
        test_death();
        test_hold();
        test_alert();
        test_auto_sleep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controlador_estados_param.md
Name: controlador_estados_param

Overview:
Parametrised successor of the Tamagotchi state controller. It evaluates pet state once per tick from two latched buttons and the hunger/happiness/sleep stats. Compared with the previous block it adds a configurable tick divider, a long-press return to INTRO, a low-stat alert and an optional idle auto-sleep. It sits between the button inputs and stat counters on one side, and the display/animation logic on the other.

Parameters:
STAT_W, 8, width of fome/felicidade/sono
TICK_DIV, 4194304, clk cycles per evaluation tick (must be >= 2)
RESET_HOLD_CYC, 4194304, consecutive cycles with b1 and b2 both high that arm a return to INTRO (must be >= 1)
LOW_THR, 32, a stat strictly below this value raises alerta
IDLE_TIMEOUT, 16, ticks in IDLE with no button before auto-sleep (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
b1  in  1  button 1, raw level, already synchronised upstream
b2  in  1  button 2, raw level, already synchronised upstream
fome  in  STAT_W  hunger stat
felicidade  in  STAT_W  happiness stat
sono  in  STAT_W  sleep stat
estado  out  5  one-hot state: INTRO=0, IDLE=1, DORMINDO=2, COMENDO=4, DANDO_AULA=8, MORTO=16
alerta  out  1  registered low-stat warning
tick  out  1  one-cycle pulse in the cycle after each evaluation

Behaviour:
- Reset (asynchronous, rst_n=0): estado=INTRO, alerta=0, tick=0; all counters and latches cleared.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - The evaluation cycle is the cycle where count==TICK_DIV-1.
- Button latches:
  - b1_lat sets on any cycle b1=1; b2_lat likewise for b2.
  - The value used at evaluation is b1_lat|b1 (b2 likewise), so a press in the evaluation cycle itself counts.
  - Both latches clear in the evaluation cycle.
- Hold counter:
  - Increments every cycle with b1&b2, saturating at RESET_HOLD_CYC.
  - Clears on any cycle where either button is low.
  - rst_req = (hold==RESET_HOLD_CYC).
- Evaluation, in priority order:
  1. rst_req: estado<=INTRO; hold counter clears.
  2. estado==MORTO, or any stat==0: estado<=MORTO. MORTO is sticky; only rst_req or rst_n leave it.
  3. estado==IDLE:
     - b1 only -> COMENDO
     - b2 only -> DORMINDO
     - both -> DANDO_AULA
     - neither -> IDLE
  4. INTRO/COMENDO/DORMINDO/DANDO_AULA: any button -> IDLE; otherwise hold state.
- estado changes only in the cycle after an evaluation; no change between ticks.
- alerta: registered every cycle; 1 iff any stat < LOW_THR and estado!=MORTO.
- tick: registered copy of the evaluation strobe.
- Stats are compared unsigned at width STAT_W.
- Stats changing between ticks have no effect on estado until the next evaluation.

Optional Feature:
CONTROLADOR_AUTO_SLEEP_EN
- Defined:
  - idle_cnt increments at each evaluation where estado==IDLE and no button is pressed.
  - idle_cnt clears on any button, on leaving IDLE, or on rst_req.
  - When idle_cnt reaches IDLE_TIMEOUT at an evaluation, estado<=DORMINDO (priority just below MORTO) and idle_cnt clears.
- Undefined: idle_cnt does not exist; IDLE persists indefinitely without input.

Decomposition:
- Package tamagotchi_pkg holds:
  - the five one-hot state localparams and the 5-bit state width
  - STAT_W default
- Sub-module divisor_tick(TICK_DIV) generates the evaluation strobe; it is also reused by the stat decay counters.

Test Plan (TICK_DIV=4, RESET_HOLD_CYC=8, LOW_THR=16, IDLE_TIMEOUT=3, all stats=100 unless stated):
- Reset, then a 1-cycle b2 pulse mid-tick -> estado INTRO->IDLE at the next evaluation; no earlier change; tick pulses every 4 cycles.
- From IDLE: a 1-cycle b1 pulse two cycles before evaluation -> COMENDO; next b1 pulse -> IDLE; b1 and b2 pulsed in the same tick window -> DANDO_AULA.
- sono=0 while in DORMINDO -> MORTO at the next evaluation; then stats restored to 100 plus short b1 presses -> stays MORTO.
- From MORTO: hold b1&b2 high for 10 cycles -> estado=INTRO at the first evaluation after the 8th held cycle. Holding only 7 cycles, then release -> no reset.
- fome=15 in IDLE -> alerta=1 one cycle later; fome=16 -> alerta=0; fome=0 -> MORTO and alerta=0.
- With CONTROLADOR_AUTO_SLEEP_EN: 3 idle evaluations -> DORMINDO; a b2 press at the 2nd evaluation resets the count. Without the macro: IDLE is held for 10 evaluations.
